// File: rtl/pool_output_streamer.sv
// pool_output_streamer
//   Captures a whole pooled feature map on a one-cycle valid_in pulse and
//   replays it as a row-major element stream with a valid/ready handshake.
//
//   Parameters: ELEM_WIDTH, MAX_IMG_HEIGHT, MAX_IMG_WIDTH
//   Ports:
//     clk, rst            rising-edge clock, synchronous active-high reset
//     valid_in, data_in   frame-ready pulse and flat frame
//                         (element (r,c) at (r*MAX_IMG_WIDTH+c)*ELEM_WIDTH)
//     out_height/width    valid frame dimensions (1..MAX)
//     m_valid/m_ready     stream handshake
//     m_data              current element
//     m_row_last, m_last  last column of row / last element of frame
//     busy                frame held and not fully drained
//     cfg_err             one-cycle pulse when a frame is rejected
//     drop_cnt            (only with POOL_STREAM_DROP_CNT_EN) saturating
//                         count of frames dropped while streaming
//
//   Optional feature macro: POOL_STREAM_DROP_CNT_EN
module pool_output_streamer #(
  parameter int ELEM_WIDTH     = 8,
  parameter int MAX_IMG_HEIGHT = 32,
  parameter int MAX_IMG_WIDTH  = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              valid_in,
  input  logic [MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] data_in,
  input  logic [7:0]                                        out_height,
  input  logic [7:0]                                        out_width,
  output logic                                              m_valid,
  input  logic                                              m_ready,
  output logic [ELEM_WIDTH-1:0]                             m_data,
  output logic                                              m_row_last,
  output logic                                              m_last,
  output logic                                              busy,
  output logic                                              cfg_err
`ifdef POOL_STREAM_DROP_CNT_EN
  ,
  output logic [15:0]                                       drop_cnt
`endif
);

  localparam int NUM_ELEMS = MAX_IMG_HEIGHT * MAX_IMG_WIDTH;
  localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state;
  logic [7:0]            row, col, height, width;
  logic [ELEM_WIDTH-1:0] frame [NUM_ELEMS];
  logic [IDX_W-1:0]      idx;
  logic                  dims_ok, at_row_end, at_frame_end;
  logic                  hs, final_hs, accept;

  assign dims_ok = (out_height != 8'd0) && (out_width != 8'd0) &&
                   (int'(out_height) <= MAX_IMG_HEIGHT) &&
                   (int'(out_width)  <= MAX_IMG_WIDTH);

  // Boundary tests use the captured dimensions only.
  assign at_row_end   = (col == width - 8'd1);
  assign at_frame_end = at_row_end && (row == height - 8'd1);

  assign m_valid  = (state == STREAM);
  assign busy     = m_valid;
  assign hs       = m_valid && m_ready;
  assign final_hs = hs && at_frame_end;

  // A new frame is taken when idle, or back-to-back on the final handshake.
  assign accept = valid_in && ((state == IDLE) || final_hs);

  assign idx        = IDX_W'(int'(row) * MAX_IMG_WIDTH + int'(col));
  // Outputs are gated by state so they read 0 while idle/after reset even
  // though the frame storage itself is never cleared.
  assign m_data     = m_valid ? frame[idx] : '0;
  assign m_row_last = m_valid && at_row_end;
  assign m_last     = m_valid && at_frame_end;

  // Frame storage: no reset, written only on an accepted, well-formed frame.
  always_ff @(posedge clk) begin
    if (!rst && accept && dims_ok) begin
      for (int i = 0; i < NUM_ELEMS; i++)
        frame[i] <= data_in[i*ELEM_WIDTH +: ELEM_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= 8'd0;
      col     <= 8'd0;
      height  <= 8'd0;
      width   <= 8'd0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (accept) begin
        row <= 8'd0;
        col <= 8'd0;
        if (dims_ok) begin
          state  <= STREAM;
          height <= out_height;
          width  <= out_width;
        end else begin
          // Also covers a bad frame arriving on the final handshake: the
          // current frame still finishes, the new one is refused.
          state   <= IDLE;
          cfg_err <= 1'b1;
        end
      end else if (hs) begin
        if (at_row_end) begin
          col <= 8'd0;
          if (at_frame_end) begin
            state <= IDLE;
            row   <= 8'd0;
          end else begin
            row <= row + 8'd1;
          end
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

`ifdef POOL_STREAM_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= 16'd0;
    else if (valid_in && (state == STREAM) && !final_hs && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
